// File: rtl/ecc_correct.sv
`default_nettype none
// ============================================================================
// Module   : ecc_correct
// Purpose  : SEC/DED correction stage for a (39,32) Hsiao codeword plus one
//            spare bit. It takes the syndrome from the upstream generator,
//            flips the faulty data or check bit, and classifies the word as
//            clean, correctable (sbe) or uncorrectable (ue). The result is
//            presented through a registered valid/ready stage. Saturating
//            error counters and a sticky first-error capture are kept for
//            software.
// Ports    : clk, rst_n             - clock, async active-low reset
//            in_valid/in_ready      - input handshake (ready passes through)
//            in_cw[39:0], in_syn[6:0] - codeword {spare, chk, data}, syndrome
//            out_valid/out_ready    - registered output handshake
//            out_data, out_chk, out_spare, out_sbe, out_ue, out_err_pos
//            sbe_cnt, ue_cnt        - saturating per-word error counters
//            cap_valid, cap_syn, cap_ue - sticky first-error capture
//            clr                    - synchronous clear of counters/capture
// Revision : 1.0 - initial release
// ============================================================================
module ecc_correct (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [39:0] in_cw,
  input  logic [6:0]  in_syn,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [6:0]  out_chk,
  output logic        out_spare,
  output logic        out_sbe,
  output logic        out_ue,
  output logic [5:0]  out_err_pos,
  output logic [15:0] sbe_cnt,
  output logic [15:0] ue_cnt,
  output logic        cap_valid,
  output logic [6:0]  cap_syn,
  output logic        cap_ue,
  input  logic        clr
);

  // Hsiao data-column syndromes, indexed by data bit position.
  localparam logic [6:0] c_col [0:31] = '{
    7'h07, 7'h0B, 7'h13, 7'h23, 7'h43, 7'h0D, 7'h15, 7'h25,
    7'h45, 7'h70, 7'h68, 7'h64, 7'h62, 7'h61, 7'h58, 7'h54,
    7'h52, 7'h51, 7'h0E, 7'h1C, 7'h38, 7'h16, 7'h26, 7'h1A,
    7'h2A, 7'h32, 7'h49, 7'h29, 7'h4A, 7'h19, 7'h4C, 7'h34
  };
  localparam logic [5:0]  c_pos_none = 6'd63;
  localparam logic [15:0] c_cnt_max  = 16'hFFFF;

  // --------------------------------------------------------------------------
  // Syndrome decode
  // --------------------------------------------------------------------------
  logic        w_data_hit;
  logic [4:0]  w_data_idx;
  logic        w_chk_hit;
  logic [2:0]  w_chk_idx;
  logic        w_sbe;
  logic        w_ue;
  logic [5:0]  w_pos;
  logic [31:0] w_data_fix;
  logic [6:0]  w_chk_fix;
  logic        w_accept;
  logic        w_err;

  always_comb begin
    w_data_hit = 1'b0;
    w_data_idx = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (in_syn == c_col[i]) begin
        w_data_hit = 1'b1;
        w_data_idx = 5'(i);
      end
    end
  end

  // A single set syndrome bit points at the matching check bit.
  always_comb begin
    w_chk_hit = (in_syn != 7'd0) && ((in_syn & (in_syn - 7'd1)) == 7'd0);
    w_chk_idx = 3'd0;
    for (int k = 0; k < 7; k++) begin
      if (in_syn[k]) begin
        w_chk_idx = 3'(k);
      end
    end
  end

  always_comb begin
    w_sbe      = w_data_hit | w_chk_hit;
    // Any nonzero syndrome that is neither a data column nor one-hot.
    w_ue       = (in_syn != 7'd0) && !w_sbe;
    w_data_fix = in_cw[31:0];
    w_chk_fix  = in_cw[38:32];
    w_pos      = c_pos_none;
    if (w_data_hit) begin
      w_data_fix = in_cw[31:0] ^ (32'd1 << w_data_idx);
      w_pos      = {1'b0, w_data_idx};
    end else if (w_chk_hit) begin
      w_chk_fix  = in_cw[38:32] ^ in_syn;
      w_pos      = 6'd32 + {3'd0, w_chk_idx};
    end
  end

  // --------------------------------------------------------------------------
  // Handshake: ready passes straight through, there is no skid buffer.
  // --------------------------------------------------------------------------
  logic r_valid;

  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_err    = w_sbe || w_ue;

  // --------------------------------------------------------------------------
  // Output register stage
  // --------------------------------------------------------------------------
  logic [31:0] r_data;
  logic [6:0]  r_chk;
  logic        r_spare;
  logic        r_sbe;
  logic        r_ue;
  logic [5:0]  r_pos;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= 32'd0;
      r_chk   <= 7'd0;
      r_spare <= 1'b0;
      r_sbe   <= 1'b0;
      r_ue    <= 1'b0;
      r_pos   <= c_pos_none;
    end else begin
      if (w_accept) begin
        r_valid <= 1'b1;
        r_data  <= w_data_fix;
        r_chk   <= w_chk_fix;
        r_spare <= in_cw[39];
        r_sbe   <= w_sbe;
        r_ue    <= w_ue;
        r_pos   <= w_pos;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Error counters and first-error capture; clr has priority over updates.
  // --------------------------------------------------------------------------
  logic [15:0] r_sbe_cnt;
  logic [15:0] r_ue_cnt;
  logic        r_cap_valid;
  logic [6:0]  r_cap_syn;
  logic        r_cap_ue;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sbe_cnt   <= 16'd0;
      r_ue_cnt    <= 16'd0;
      r_cap_valid <= 1'b0;
      r_cap_syn   <= 7'd0;
      r_cap_ue    <= 1'b0;
    end else if (clr) begin
      r_sbe_cnt   <= 16'd0;
      r_ue_cnt    <= 16'd0;
      r_cap_valid <= 1'b0;
      r_cap_syn   <= 7'd0;
      r_cap_ue    <= 1'b0;
    end else if (w_accept) begin
      if (w_sbe && (r_sbe_cnt != c_cnt_max)) begin
        r_sbe_cnt <= r_sbe_cnt + 16'd1;
      end
      if (w_ue && (r_ue_cnt != c_cnt_max)) begin
        r_ue_cnt <= r_ue_cnt + 16'd1;
      end
      if (w_err && !r_cap_valid) begin
        r_cap_valid <= 1'b1;
        r_cap_syn   <= in_syn;
        r_cap_ue    <= w_ue;
      end
    end
  end

  assign out_valid   = r_valid;
  assign out_data    = r_data;
  assign out_chk     = r_chk;
  assign out_spare   = r_spare;
  assign out_sbe     = r_sbe;
  assign out_ue      = r_ue;
  assign out_err_pos = r_pos;
  assign sbe_cnt     = r_sbe_cnt;
  assign ue_cnt      = r_ue_cnt;
  assign cap_valid   = r_cap_valid;
  assign cap_syn     = r_cap_syn;
  assign cap_ue      = r_cap_ue;

endmodule
`default_nettype wire

// File: tb/tb_ecc_correct.sv
`default_nettype none
// ============================================================================
// Module   : tb_ecc_correct
// Purpose  : Self-checking bench for ecc_correct: directed vector table,
//            per-bit data error sweep, back-pressure, saturation/clear and
//            reset-mid-stall sequences, plus randomized traffic against a
//            behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ecc_correct;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [39:0] in_cw;
  logic [6:0]  in_syn;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [6:0]  out_chk;
  logic        out_spare;
  logic        out_sbe;
  logic        out_ue;
  logic [5:0]  out_err_pos;
  logic [15:0] sbe_cnt;
  logic [15:0] ue_cnt;
  logic        cap_valid;
  logic [6:0]  cap_syn;
  logic        cap_ue;
  logic        clr;

  ecc_correct dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_cw      (in_cw),
    .in_syn     (in_syn),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_chk    (out_chk),
    .out_spare  (out_spare),
    .out_sbe    (out_sbe),
    .out_ue     (out_ue),
    .out_err_pos(out_err_pos),
    .sbe_cnt    (sbe_cnt),
    .ue_cnt     (ue_cnt),
    .cap_valid  (cap_valid),
    .cap_syn    (cap_syn),
    .cap_ue     (cap_ue),
    .clr        (clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [6:0] cols [32] = '{
    7'h07, 7'h0B, 7'h13, 7'h23, 7'h43, 7'h0D, 7'h15, 7'h25,
    7'h45, 7'h70, 7'h68, 7'h64, 7'h62, 7'h61, 7'h58, 7'h54,
    7'h52, 7'h51, 7'h0E, 7'h1C, 7'h38, 7'h16, 7'h26, 7'h1A,
    7'h2A, 7'h32, 7'h49, 7'h29, 7'h4A, 7'h19, 7'h4C, 7'h34
  };

  typedef struct {
    logic [39:0] cw;
    logic [6:0]  syn;
    logic [31:0] d;
    logic [6:0]  c;
    logic        sp;
    logic        sbe;
    logic        ue;
    logic [5:0]  pos;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: look the syndrome up in the code's column list.
  function automatic void model(input logic [39:0] cw, input logic [6:0] syn,
                                output logic [31:0] d, output logic [6:0] c,
                                output logic sbe, output logic ue,
                                output logic [5:0] pos);
    d   = cw[31:0];
    c   = cw[38:32];
    sbe = 1'b0;
    ue  = 1'b0;
    pos = 6'd63;
    if (syn != 7'd0) begin
      for (int i = 0; i < 32; i++) begin
        if (cols[i] == syn) begin
          d[i] = ~d[i];
          sbe  = 1'b1;
          pos  = 6'(i);
        end
      end
      for (int k = 0; k < 7; k++) begin
        if (syn == 7'(1 << k)) begin
          c[k] = ~c[k];
          sbe  = 1'b1;
          pos  = 6'(32 + k);
        end
      end
      ue = !sbe;
    end
  endfunction

  // One word through an idle stage, outputs sampled 1 time unit after the edge.
  task automatic send(input logic [39:0] cw, input logic [6:0] syn);
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_cw     = cw;
    in_syn    = syn;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
  endtask

  // Random-phase model state
  logic        m_ov, m_sbe, m_ue, m_sp, m_capv, m_capue, acc, exp_rdy;
  logic [31:0] m_d;
  logic [6:0]  m_c, m_capsyn;
  logic [5:0]  m_pos;
  logic [31:0] n_d;
  logic [6:0]  n_c;
  logic        n_sbe, n_ue, n_sp;
  logic [5:0]  n_pos;
  int          m_sbe_cnt, m_ue_cnt;
  logic [31:0] hold_d;

  initial begin
    vecs[0] = '{40'h00DEADBEEF,                 7'h00, 32'hDEADBEEF, 7'h00, 1'b0, 1'b0, 1'b0, 6'd63};
    vecs[1] = '{{1'b0, 7'h55, 32'h12345678},    7'h03, 32'h12345678, 7'h55, 1'b0, 1'b0, 1'b1, 6'd63};
    vecs[2] = '{{1'b1, 7'h2A, 32'hCAFEF00D},    7'h7F, 32'hCAFEF00D, 7'h2A, 1'b1, 1'b0, 1'b1, 6'd63};
    vecs[3] = '{{1'b0, 7'h7F, 32'h00000000},    7'h10, 32'h00000000, 7'h6F, 1'b0, 1'b1, 1'b0, 6'd36};
    vecs[4] = '{{1'b1, 7'h00, 32'hFFFFFFFF},    7'h34, 32'h7FFFFFFF, 7'h00, 1'b1, 1'b1, 1'b0, 6'd31};
    vecs[5] = '{{1'b0, 7'h01, 32'h00000000},    7'h40, 32'h00000000, 7'h41, 1'b0, 1'b1, 1'b0, 6'd38};
    vecs[6] = '{{1'b0, 7'h00, 32'h00000100},    7'h45, 32'h00000000, 7'h00, 1'b0, 1'b1, 1'b0, 6'd8};
    vecs[7] = '{{1'b0, 7'h11, 32'hA5A5A5A5},    7'h0F, 32'hA5A5A5A5, 7'h11, 1'b0, 1'b0, 1'b1, 6'd63};
    vecs[8] = '{{1'b0, 7'h22, 32'h0F0F0F0F},    7'h31, 32'h0F0F0F0F, 7'h22, 1'b0, 1'b0, 1'b1, 6'd63};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr = 1'b0;
    in_cw = 40'd0; in_syn = 7'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_chk", out_chk, 0);
    check("rst_out_spare", out_spare, 0);
    check("rst_out_sbe_ue", {out_sbe, out_ue}, 0);
    check("rst_err_pos", out_err_pos, 63);
    check("rst_cnts", {sbe_cnt, ue_cnt}, 0);
    check("rst_cap", {cap_valid, cap_syn, cap_ue}, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table
    for (int v = 0; v < 9; v++) begin
      send(vecs[v].cw, vecs[v].syn);
      check($sformatf("vec%0d_valid", v), out_valid, 1);
      check($sformatf("vec%0d_data", v), out_data, vecs[v].d);
      check($sformatf("vec%0d_chk", v), out_chk, vecs[v].c);
      check($sformatf("vec%0d_spare", v), out_spare, vecs[v].sp);
      check($sformatf("vec%0d_sbe_ue", v), {out_sbe, out_ue}, {vecs[v].sbe, vecs[v].ue});
      check($sformatf("vec%0d_pos", v), out_err_pos, vecs[v].pos);
      if (v == 0) check("clean_cnts", {sbe_cnt, ue_cnt}, 0);
    end
    check("tbl_sbe_cnt", sbe_cnt, 4);
    check("tbl_ue_cnt", ue_cnt, 4);
    check("tbl_cap", {cap_valid, cap_syn, cap_ue}, {1'b1, 7'h03, 1'b1});

    // Clear, then single error on every data bit
    @(negedge clk); clr = 1'b1;
    @(posedge clk); #1; clr = 1'b0;
    check("clr_cnts", {sbe_cnt, ue_cnt}, 0);
    check("clr_cap", {cap_valid, cap_syn, cap_ue}, 0);
    for (int i = 0; i < 32; i++) begin
      send(40'd0, cols[i]);
      check($sformatf("bit%0d_data", i), out_data, 32'd1 << i);
      check($sformatf("bit%0d_sbe_ue", i), {out_sbe, out_ue}, 2'b10);
      check($sformatf("bit%0d_pos", i), out_err_pos, 6'(i));
    end
    check("sweep_sbe_cnt", sbe_cnt, 32);
    check("sweep_cap", {cap_valid, cap_syn, cap_ue}, {1'b1, 7'h07, 1'b0});

    // Back-pressure: clean words, outputs held while out_ready is low
    send(40'h0011111111, 7'h00);
    hold_d = out_data;
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b0; in_cw = 40'h0022222222; in_syn = 7'h00;
    #1;
    check("bp_in_ready_low", in_ready, 0);
    for (int s = 0; s < 3; s++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d_valid", s), out_valid, 1);
      check($sformatf("bp_hold%0d_data", s), out_data, hold_d);
      check($sformatf("bp_hold%0d_in_ready", s), in_ready, 0);
    end
    check("bp_cnt_unchanged", sbe_cnt, 32);
    @(negedge clk); out_ready = 1'b1;
    #1;
    check("bp_in_ready_release", in_ready, 1);
    @(posedge clk); #1;
    check("bp_word2", out_data, 32'h22222222);
    @(negedge clk); in_cw = 40'h0033333333;
    @(posedge clk); #1;
    check("bp_word3", out_data, 32'h33333333);
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1;
    check("bp_drain", out_valid, 0);

    // Randomized traffic against the reference model
    @(negedge clk); clr = 1'b1;
    @(posedge clk); #1;
    m_ov = 1'b0; m_sbe_cnt = 0; m_ue_cnt = 0; m_capv = 1'b0; m_capsyn = 7'd0; m_capue = 1'b0;
    m_d = '0; m_c = '0; m_sp = 1'b0; m_sbe = 1'b0; m_ue = 1'b0; m_pos = 6'd63;
    for (int n = 0; n < 2000; n++) begin
      int r;
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      clr       = ($urandom_range(0, 49) == 0);
      in_cw     = {8'($urandom), 32'($urandom)};
      r = $urandom_range(0, 9);
      if (r < 2)      in_syn = 7'h00;
      else if (r < 5) in_syn = cols[$urandom_range(0, 31)];
      else if (r < 7) in_syn = 7'(1 << $urandom_range(0, 6));
      else            in_syn = 7'($urandom);
      #1;
      exp_rdy = !m_ov || out_ready;
      check("rnd_in_ready", in_ready, exp_rdy);
      acc = in_valid && exp_rdy;
      model(in_cw, in_syn, n_d, n_c, n_sbe, n_ue, n_pos);
      n_sp = in_cw[39];
      @(posedge clk); #1;
      if (acc) begin
        m_ov = 1'b1; m_d = n_d; m_c = n_c; m_sp = n_sp;
        m_sbe = n_sbe; m_ue = n_ue; m_pos = n_pos;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      if (clr) begin
        m_sbe_cnt = 0; m_ue_cnt = 0; m_capv = 1'b0; m_capsyn = 7'd0; m_capue = 1'b0;
      end else if (acc) begin
        if (n_sbe && m_sbe_cnt < 65535) m_sbe_cnt++;
        if (n_ue && m_ue_cnt < 65535) m_ue_cnt++;
        if ((n_sbe || n_ue) && !m_capv) begin
          m_capv = 1'b1; m_capsyn = in_syn; m_capue = n_ue;
        end
      end
      check("rnd_out_valid", out_valid, m_ov);
      if (m_ov) begin
        check("rnd_word", {out_data, out_chk, out_spare}, {m_d, m_c, m_sp});
        check("rnd_class", {out_sbe, out_ue, out_err_pos}, {m_sbe, m_ue, m_pos});
      end
      check("rnd_cnts", {sbe_cnt, ue_cnt}, {16'(m_sbe_cnt), 16'(m_ue_cnt)});
      check("rnd_cap", {cap_valid, cap_syn, cap_ue}, {m_capv, m_capsyn, m_capue});
    end

    // Saturation: stream sbe words back to back
    @(negedge clk);
    clr = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b1; in_cw = 40'd0; in_syn = 7'h07;
    repeat (65534) @(posedge clk);
    #1;
    check("sat_fffe", sbe_cnt, 16'hFFFE);
    repeat (3) @(posedge clk);
    #1;
    check("sat_ffff", sbe_cnt, 16'hFFFF);

    // clr coinciding with an accepted ue word
    @(negedge clk);
    clr = 1'b1; in_syn = 7'h03; in_cw = 40'h00ABCDEF01;
    @(posedge clk); #1;
    check("clr_ue_cnts", {sbe_cnt, ue_cnt}, 0);
    check("clr_ue_capv", cap_valid, 0);
    check("clr_ue_word", {out_ue, out_sbe, out_data}, {1'b1, 1'b0, 32'hABCDEF01});
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;

    // Reset while a word is stalled
    send(40'h0055AA55AA, 7'h00);
    @(negedge clk); out_ready = 1'b0;
    @(posedge clk); #1;
    check("stall_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_stall_valid", out_valid, 0);
    check("rst_stall_pos", out_err_pos, 63);
    check("rst_stall_data", out_data, 0);
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_rst_valid", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ecc_correct.md
# ecc_correct

Single-error-correct / double-error-detect stage directly downstream of the 40-bit syndrome generator. It takes the pass-through codeword plus the 7-bit syndrome, flips the faulty bit, and classifies the word as clean, correctable or uncorrectable. Results go out through a registered valid/ready output stage. The block also keeps saturating error counters and a sticky first-error capture for software.

## Interface
- No parameters; widths are fixed by the (39,32) Hsiao code plus 1 spare bit.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  codeword/syndrome pair valid
- in_ready  out  1  stage can accept this cycle
- in_cw  in  40  [31:0] data, [38:32] check bits, [39] spare
- in_syn  in  7  syndrome from upstream for this in_cw
- out_valid  out  1  registered result valid
- out_ready  in  1  consumer accepts result
- out_data  out  32  corrected data
- out_chk  out  7  corrected check bits
- out_spare  out  1  in_cw[39], passed through unchanged
- out_sbe  out  1  single-bit error corrected in this word
- out_ue  out  1  uncorrectable error in this word
- out_err_pos  out  6  0–31 data bit, 32–38 check bit (32+k), 63 = none
- sbe_cnt  out  16  saturating count of accepted words with out_sbe
- ue_cnt  out  16  saturating count of accepted words with out_ue
- cap_valid  out  1  sticky: an error word has been captured
- cap_syn  out  7  syndrome of first captured error
- cap_ue  out  1  first captured error was uncorrectable
- clr  in  1  synchronous clear of counters and capture

## Operation
- Accept when in_valid && in_ready. in_ready = !out_valid || out_ready.
- Data column syndromes (S6..S0, hex), bits 0–31:
  - bits 0–8: 07 0B 13 23 43 0D 15 25 45
  - bits 9–17: 70 68 64 62 61 58 54 52 51
  - bits 18–25: 0E 1C 38 16 26 1A 2A 32
  - bits 26–31: 49 29 4A 19 4C 34
- Check-bit column k is the one-hot syndrome 1<<k.
- Classification of in_syn:
  - 0: clean. sbe=0, ue=0, pos=63.
  - Equal to data column i: flip data bit i. sbe=1, pos=i.
  - One-hot bit k: flip check bit k, data unchanged. sbe=1, pos=32+k.
  - Any other nonzero value (even weight, or unmatched odd weight): ue=1, pos=63, data and check bits passed through uncorrected.
- sbe and ue are never both 1.
- The syndrome is trusted as given; no recomputation from in_cw.
- Counters increment once per accepted word with sbe (or ue). They saturate at 0xFFFF.
- Capture: on the first accepted error word while cap_valid=0, load cap_syn and cap_ue and set cap_valid. Later errors do not overwrite it.
- clr: zeroes sbe_cnt, ue_cnt and cap_*. If clr coincides with an accepted error word, clr wins: the counters read 0 and cap_valid stays 0 for that cycle.

## Timing
- Latency 1 cycle: a word accepted at edge N appears on out_* after edge N.
- Throughput 1 word/cycle while out_ready=1.
- While out_valid && !out_ready:
  - all out_* hold stable;
  - in_ready=0.
- in_ready combinationally depends on out_ready (pass-through ready, no skid buffer).
- Counters and capture update on the acceptance edge, in the same edge as out_* loads.
- Reset (async assert, sync-deassert done externally):
  - out_valid=0, out_data=0, out_chk=0, out_spare=0, out_sbe=0, out_ue=0;
  - out_err_pos=63;
  - sbe_cnt=0, ue_cnt=0, cap_valid=0, cap_syn=0, cap_ue=0.
- Reset mid-transfer drops the held word. There is no replay.

## Test plan
- Clean word: in_cw=0x0_DEADBEEF with chk=0, syn=0x00, out_ready=1 → next cycle out_data=0xDEADBEEF, sbe=0, ue=0, pos=63. Counters unchanged.
- Data single error: every data bit i, data=0x00000000, syn=column(i) → out_data=1<<i, sbe=1, pos=i. After all 32 words, sbe_cnt=32.
- Check-bit error: syn=0x10, chk=0x7F → out_chk=0x6F, data unchanged, pos=36, sbe=1.
- Uncorrectable: syn=0x03 (even weight) then syn=0x7F (weight 7) → ue=1 both times, data passed unchanged, ue_cnt=2. cap_syn=0x03, cap_ue=1 (first error only).
- Back-pressure: hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, out_* stable, no counter change. Release → one word per cycle with no loss or duplication.
- Saturation and clear: force 65 537 sbe words → sbe_cnt=0xFFFF. Assert clr together with an accepted ue word → all counters 0, cap_valid=0. Assert rst_n low mid-stall → out_valid=0 immediately.
